ram_test_sequencer: RTL and testbench

//  Wishbone-style initiator that exercises a word-addressed RAM responder through the

---
 rtl/ram_test_pkg.sv | 30 +++
 rtl/wb_ack_watchdog.sv | 31 +++
 rtl/ram_test_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_ram_test_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_test_pkg.sv
// Shared definitions for the RAM test sequencer: FSM states, LED bit positions
// and the write/readback data pattern.
package ram_test_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned LED_PASS = 4;
    localparam int unsigned LED_RUN  = 5;
    localparam int unsigned LED_TMO  = 6;
    localparam int unsigned LED_MIS  = 7;

    typedef enum logic [2:0] {
        ST_WRITE     = 3'd0,
        ST_WRITE_GAP = 3'd1,
        ST_READ      = 3'd2,
        ST_READ_GAP  = 3'd3,
        ST_PASS_END  = 3'd4,
        ST_FAIL      = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

    // Pass 0 writes the seeded index pattern, pass 1 writes its complement.
    function automatic logic [WORD_W-1:0] pattern(input logic [15:0] index,
                                                   input logic pass,
                                                   input logic [WORD_W-1:0] seed);
        logic [WORD_W-1:0] word;
        word = {~index, index} ^ seed;
        return pass ? ~word : word;
    endfunction

endpackage

// File: rtl/wb_ack_watchdog.sv
// Counts strobe cycles that have not been acknowledged and flags when the
// responder has kept the initiator waiting for ACK_TIMEOUT cycles.
module wb_ack_watchdog #(
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic start_i,
    input  logic busy_i,
    input  logic ack_i,
    output logic timeout_c_o
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;

    // Flags in the ACK_TIMEOUT-th waiting cycle so the initiator can drop strobe on that edge.
    assign timeout_c_o = busy_i && !ack_i && (count_q == CNT_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (start_i) begin
            count_q <= '0;
        end else if (busy_i && !ack_i && !timeout_c_o) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ram_test_sequencer.sv
// Wishbone-style initiator that writes a pattern over a RAM window, reads it back
// and compares, then repeats with inverted data; status goes to LEDs and capture registers.
module ram_test_sequencer
    import ram_test_pkg::*;
#(
    parameter int unsigned ADDRESS_COUNT = 256,
    parameter logic [31:0] BASE_ADDRESS  = 32'h0,
    parameter logic [31:0] SEED          = 32'h5A5A0000,
    parameter int unsigned ACK_TIMEOUT   = 1024,
    parameter bit          LOOP          = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        wbCycleStrobe,
    output logic        wbWriteEnable,
    output logic [31:0] wbAddress,
    output logic [31:0] wbWriteData,
    input  logic [31:0] wbReadData,
    input  logic        wbAck,
    output logic [7:0]  leds,
    output logic [31:0] errorAddress,
    output logic [31:0] errorExpected,
    output logic [31:0] errorActual
);

    localparam int unsigned IDX_W = $clog2(ADDRESS_COUNT);

    state_e             state_q;
    logic [IDX_W-1:0]   index_q;
    logic               pass_q;
    logic [3:0]         iter_q;
    logic               stb_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        data_q;
    logic [31:0]        rdata_q;
    logic               running_q;
    logic               tmo_q;
    logic               mis_q;
    logic [31:0]        err_addr_q;
    logic [31:0]        err_exp_q;
    logic [31:0]        err_act_q;

    logic               last_c;
    logic               timeout_c;
    logic [IDX_W-1:0]   next_index_d;
    logic               next_pass_d;
    logic [31:0]        issue_addr_d;
    logic [31:0]        issue_data_d;

    wb_ack_watchdog #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_watchdog (
        .clock       (clock),
        .reset       (reset),
        .start_i     (!stb_q),
        .busy_i      (stb_q),
        .ack_i       (wbAck),
        .timeout_c_o (timeout_c)
    );

    // Address and word of the transfer issued on the next edge, when one is issued.
    always_comb begin
        last_c       = (index_q == IDX_W'(ADDRESS_COUNT - 1));
        next_index_d = index_q + IDX_W'(1);
        next_pass_d  = pass_q;
        case (state_q)
            ST_WRITE:     next_index_d = index_q;
            ST_WRITE_GAP: if (last_c) next_index_d = '0;
            ST_PASS_END: begin
                next_index_d = '0;
                next_pass_d  = LOOP ? ~pass_q : 1'b1;
            end
            default: ;
        endcase
        issue_addr_d = BASE_ADDRESS + 32'(next_index_d);
        issue_data_d = pattern(16'(next_index_d), next_pass_d, SEED);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_WRITE;
            index_q    <= '0;
            pass_q     <= 1'b0;
            iter_q     <= '0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rdata_q    <= '0;
            running_q  <= 1'b0;
            tmo_q      <= 1'b0;
            mis_q      <= 1'b0;
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_act_q  <= '0;
        end else begin
            running_q <= 1'b1;
            case (state_q)
                ST_WRITE, ST_READ: begin
                    if (!stb_q) begin
                        // Only reached in WRITE straight out of reset.
                        stb_q  <= 1'b1;
                        we_q   <= (state_q == ST_WRITE);
                        addr_q <= issue_addr_d;
                        data_q <= issue_data_d;
                    end else if (timeout_c) begin
                        stb_q      <= 1'b0;
                        tmo_q      <= 1'b1;
                        err_addr_q <= addr_q;
                        running_q  <= 1'b0;
                        state_q    <= ST_FAIL;
                    end else if (wbAck) begin
                        stb_q   <= 1'b0;
                        rdata_q <= wbReadData;
                        state_q <= (state_q == ST_WRITE) ? ST_WRITE_GAP : ST_READ_GAP;
                    end
                end
                ST_WRITE_GAP: begin
                    index_q <= next_index_d;
                    stb_q   <= 1'b1;
                    we_q    <= !last_c;
                    addr_q  <= issue_addr_d;
                    data_q  <= issue_data_d;
                    state_q <= last_c ? ST_READ : ST_WRITE;
                end
                ST_READ_GAP: begin
                    if (rdata_q != data_q) begin
                        mis_q      <= 1'b1;
                        err_addr_q <= addr_q;
                        err_exp_q  <= data_q;
                        err_act_q  <= rdata_q;
                        running_q  <= 1'b0;
                        state_q    <= ST_FAIL;
                    end else if (last_c) begin
                        state_q <= ST_PASS_END;
                    end else begin
                        index_q <= next_index_d;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= issue_addr_d;
                        data_q  <= issue_data_d;
                        state_q <= ST_READ;
                    end
                end
                ST_PASS_END: begin
                    index_q <= next_index_d;
                    pass_q  <= next_pass_d;
                    if (pass_q) iter_q <= iter_q + 4'd1;
                    if (pass_q && !LOOP) begin
                        running_q <= 1'b0;
                        state_q   <= ST_DONE;
                    end else begin
                        stb_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= issue_addr_d;
                        data_q  <= issue_data_d;
                        state_q <= ST_WRITE;
                    end
                end
                default: begin
                    stb_q     <= 1'b0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign wbCycleStrobe = stb_q;
    assign wbWriteEnable = we_q;
    assign wbAddress     = addr_q;
    assign wbWriteData   = data_q;
    assign errorAddress  = err_addr_q;
    assign errorExpected = err_exp_q;
    assign errorActual   = err_act_q;

    always_comb begin
        leds           = '0;
        leds[3:0]      = iter_q;
        leds[LED_PASS] = pass_q;
        leds[LED_RUN]  = running_q;
        leds[LED_TMO]  = tmo_q;
        leds[LED_MIS]  = mis_q;
    end

endmodule

// File: tb/tb_ram_test_sequencer.sv
// Bench for ram_test_sequencer: RAM responder model, transfer log compared against
// a hand-computed table, plus directed fail/timeout/reset/loop scenarios.
module tb_ram_test_sequencer;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Main instance: 4 words, short timeout, single iteration.
    logic        rst = 1'b1;
    logic        stb, we, ack;
    logic [31:0] addr, wdata, rdata;
    logic [7:0]  leds;
    logic [31:0] err_addr, err_exp, err_act;

    ram_test_sequencer #(
        .ADDRESS_COUNT (4),
        .BASE_ADDRESS  (32'h0),
        .SEED          (32'h5A5A0000),
        .ACK_TIMEOUT   (16),
        .LOOP          (1'b0)
    ) dut (
        .clock         (clk),
        .reset         (rst),
        .wbCycleStrobe (stb),
        .wbWriteEnable (we),
        .wbAddress     (addr),
        .wbWriteData   (wdata),
        .wbReadData    (rdata),
        .wbAck         (ack),
        .leds          (leds),
        .errorAddress  (err_addr),
        .errorExpected (err_exp),
        .errorActual   (err_act)
    );

    // Responder: configurable wait states, never-ack, and forced zero readback at address 2.
    int          delay  = 0;
    bit          noack  = 1'b0;
    bit          force2 = 1'b0;
    int          wcnt;
    logic [31:0] mem [256];
    logic [31:0] rd_word;
    xfer_t       log_q[$];

    assign rd_word = (force2 && addr == 32'd2) ? 32'd0 : mem[addr[7:0]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack   <= 1'b0;
            wcnt  <= 0;
            rdata <= '0;
        end else if (stb && !ack && !noack) begin
            if (wcnt < delay) begin
                wcnt <= wcnt + 1;
            end else begin
                ack  <= 1'b1;
                wcnt <= 0;
                if (we) begin
                    mem[addr[7:0]] <= wdata;
                    log_q.push_back(xfer_t'({1'b1, addr, wdata}));
                end else begin
                    rdata <= rd_word;
                    log_q.push_back(xfer_t'({1'b0, addr, rd_word}));
                end
            end
        end else begin
            ack <= 1'b0;
        end
    end

    // Request fields must hold while strobe waits for ack.
    int    stab_err = 0;
    bit    in_xfer  = 1'b0;
    xfer_t held;
    always @(posedge clk) begin
        if (stb && !rst) begin
            if (in_xfer && xfer_t'({we, addr, wdata}) != held) stab_err <= stab_err + 1;
            if (!in_xfer) held <= xfer_t'({we, addr, wdata});
            in_xfer <= !ack;
        end else begin
            in_xfer <= 1'b0;
        end
    end

    // Looping instance with a shifted window.
    logic        rst2 = 1'b1;
    logic        stb2, we2, ack2;
    logic [31:0] addr2, wdata2, rdata2;
    logic [7:0]  leds2;
    logic [31:0] ea2, ee2, eac2;
    logic [31:0] mem2 [256];
    int          range_err = 0;
    logic [3:0]  last_it = 4'd0;
    logic [3:0]  iters[$];

    ram_test_sequencer #(
        .ADDRESS_COUNT (4),
        .BASE_ADDRESS  (32'h10),
        .SEED          (32'h5A5A0000),
        .ACK_TIMEOUT   (1024),
        .LOOP          (1'b1)
    ) dut_loop (
        .clock         (clk),
        .reset         (rst2),
        .wbCycleStrobe (stb2),
        .wbWriteEnable (we2),
        .wbAddress     (addr2),
        .wbWriteData   (wdata2),
        .wbReadData    (rdata2),
        .wbAck         (ack2),
        .leds          (leds2),
        .errorAddress  (ea2),
        .errorExpected (ee2),
        .errorActual   (eac2)
    );

    always @(posedge clk or posedge rst2) begin
        if (rst2) begin
            ack2   <= 1'b0;
            rdata2 <= '0;
        end else if (stb2 && !ack2) begin
            ack2 <= 1'b1;
            if (we2) mem2[addr2[7:0]] <= wdata2;
            else     rdata2 <= mem2[addr2[7:0]];
            if (addr2 < 32'h10 || addr2 > 32'h13) range_err <= range_err + 1;
        end else begin
            ack2 <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst2 && leds2[3:0] != last_it) begin
            iters.push_back(leds2[3:0]);
            last_it <= leds2[3:0];
        end
    end

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    xfer_t exp_tab[16];

    task automatic run_table(input string tag);
        xfer_t got;
        check({tag, "_count"}, 65'(log_q.size()), 65'd16);
        for (int k = 0; k < 16; k++) begin
            got = (k < log_q.size()) ? log_q[k] : '0;
            check($sformatf("%s_xfer%0d", tag, k), got, exp_tab[k]);
        end
    endtask

    task automatic restart();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        log_q.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_stop(input string name, input int budget);
        int n = 0;
        while (leds[5] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_stopped"}, 65'(leds[5]), 65'd0);
    endtask

    initial begin
        int n;
        // P(i) = {~i,i} ^ 5A5A0000; pass 1 complements.
        exp_tab[0]  = '{1'b1, 32'h0, 32'hA5A50000};
        exp_tab[1]  = '{1'b1, 32'h1, 32'hA5A40001};
        exp_tab[2]  = '{1'b1, 32'h2, 32'hA5A70002};
        exp_tab[3]  = '{1'b1, 32'h3, 32'hA5A60003};
        exp_tab[4]  = '{1'b0, 32'h0, 32'hA5A50000};
        exp_tab[5]  = '{1'b0, 32'h1, 32'hA5A40001};
        exp_tab[6]  = '{1'b0, 32'h2, 32'hA5A70002};
        exp_tab[7]  = '{1'b0, 32'h3, 32'hA5A60003};
        exp_tab[8]  = '{1'b1, 32'h0, 32'h5A5AFFFF};
        exp_tab[9]  = '{1'b1, 32'h1, 32'h5A5BFFFE};
        exp_tab[10] = '{1'b1, 32'h2, 32'h5A58FFFD};
        exp_tab[11] = '{1'b1, 32'h3, 32'h5A59FFFC};
        exp_tab[12] = '{1'b0, 32'h0, 32'h5A5AFFFF};
        exp_tab[13] = '{1'b0, 32'h1, 32'h5A5BFFFE};
        exp_tab[14] = '{1'b0, 32'h2, 32'h5A58FFFD};
        exp_tab[15] = '{1'b0, 32'h3, 32'h5A59FFFC};

        repeat (3) @(negedge clk);
        rst2 = 1'b0;
        check("rst_strobe_leds", 65'({stb, we, leds}), 65'd0);
        check("rst_bus", 65'({addr, wdata}), 65'd0);
        check("rst_err", 65'(err_addr | err_exp | err_act), 65'd0);
        rst = 1'b0;
        @(negedge clk);
        check("first_leds", 65'(leds), 65'h20);
        check("first_req", 65'({stb, we, addr, wdata}), {1'b1, 1'b1, 32'h0, 32'hA5A50000});

        // Clean single iteration.
        wait_stop("clean", 500);
        run_table("clean");
        check("clean_leds", 65'(leds), 65'h11);
        check("clean_idle", 65'({stb, err_addr}), 65'd0);

        // Five wait states per word.
        delay = 5;
        restart();
        wait_stop("delay", 2000);
        run_table("delay");
        check("delay_stable", 65'(stab_err), 65'd0);
        check("delay_leds", 65'(leds), 65'h11);
        delay = 0;

        // Readback of address 2 forced to zero in pass 0.
        force2 = 1'b1;
        restart();
        wait_stop("mis", 500);
        repeat (5) @(negedge clk);
        check("mis_leds", 65'(leds), 65'h80);
        check("mis_addr", 65'(err_addr), 65'd2);
        check("mis_exp", 65'(err_exp), 65'hA5A70002);
        check("mis_act", 65'(err_act), 65'd0);
        check("mis_strobe", 65'(stb), 65'd0);
        check("mis_xfers", 65'(log_q.size()), 65'd7);
        force2 = 1'b0;

        // Responder never acknowledges.
        noack = 1'b1;
        restart();
        n = 0;
        for (int c = 0; c < 100 && leds[5]; c++) begin
            if (stb) n++;
            @(negedge clk);
        end
        check("tmo_strobe_cycles", 65'(n), 65'd16);
        check("tmo_leds", 65'(leds), 65'h40);
        check("tmo_capture", 65'({stb, err_addr, err_exp}), 65'd0);
        noack = 1'b0;

        // Asynchronous reset while the read of index 1 is outstanding.
        restart();
        n = 0;
        while (!(stb && !we && addr == 32'd1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_read_reached", 65'(stb && !we && addr == 32'd1), 65'd1);
        rst = 1'b1;
        #1;
        check("mid_reset_strobe", 65'(stb), 65'd0);
        restart();
        n = 0;
        while (log_q.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_restart_xfer", (log_q.size() > 0) ? 65'(log_q[0]) : 65'd0,
              {1'b1, 32'h0, 32'hA5A50000});

        // Looping instance: iteration count 1,2,3 and window 0x10..0x13 only.
        n = 0;
        while (iters.size() < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 3; k++)
            check($sformatf("loop_iter%0d", k), (k < iters.size()) ? 65'(iters[k]) : 65'd0,
                  65'(k + 1));
        check("loop_range", 65'(range_err), 65'd0);
        check("loop_running", 65'(leds2[7:5]), 65'b001);
        check("loop_err_regs", 65'(ea2 | ee2 | eac2), 65'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
